// File: rtl/clkgen_pkg.sv
// clkgen_pkg: definitions shared by the clock generator.
//   state_t    - FSM state encoding
//   acc_width  - phase accumulator width for a given reference frequency
//   sum_width  - width of the accumulator adder, wide enough for acc + 2*inc
package clkgen_pkg;

  localparam int INC_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  function automatic int acc_width(input int clk_mhz);
    return $clog2(clk_mhz) + 1;
  endfunction

  // The adder must hold acc (< clk_mhz) plus a doubled 8-bit increment.
  function automatic int sum_width(input int clk_mhz);
    int aw;
    aw = acc_width(clk_mhz);
    return ((aw > INC_W + 1) ? aw : INC_W + 1) + 1;
  endfunction

endpackage

// File: rtl/clkgen_acc.sv
// clkgen_acc: phase accumulator, modulo compare/subtract and out_clk toggle flop.
//   clk, rst_n - reference clock, async active-low reset
//   step       - advance the accumulator by 2*inc this cycle
//   clr        - force acc and out_clk to 0 (takes priority over step)
//   inc        - active increment in MHz
//   out_clk    - generated clock (registered)
//   rise, fall - this cycle's step toggles out_clk 0->1 / 1->0
module clkgen_acc
  import clkgen_pkg::*;
#(
  parameter int CLK_MHZ = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             step,
  input  logic             clr,
  input  logic [INC_W-1:0] inc,
  output logic             out_clk,
  output logic             rise,
  output logic             fall
);

  localparam int AW = acc_width(CLK_MHZ);
  localparam int SW = sum_width(CLK_MHZ);
  localparam logic [SW-1:0] MOD = SW'(CLK_MHZ);

  logic [AW-1:0] acc;
  logic [SW-1:0] sum;
  logic [SW-1:0] wrapped;
  logic          tgl;

  // Two phase units per MHz: out_clk toggles twice per output period.
  always_comb begin
    sum     = SW'(acc) + SW'({inc, 1'b0});
    wrapped = sum - MOD;
    tgl     = step && (sum >= MOD);
  end

  assign rise = tgl && !out_clk;
  assign fall = tgl && out_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      out_clk <= 1'b0;
    end else if (clr) begin
      acc     <= '0;
      out_clk <= 1'b0;
    end else if (step) begin
      if (tgl) begin
        acc     <= AW'(wrapped);
        out_clk <= ~out_clk;
      end else begin
        acc <= AW'(sum);
      end
    end
  end

endmodule

// File: rtl/clkgen.sv
// clkgen: programmable-frequency clock generator from a reference clock.
//   clk, rst_n        - reference clock, async active-low reset
//   en                - run request (level)
//   freq_valid/ready  - frequency change handshake, freq_mhz = new value (0 stops)
//   freq_err          - sticky: an out-of-range request was rejected
//   out_clk           - generated clock, registered
//   out_stb           - one-cycle pulse on the cycle out_clk rises
//   running           - high in RUN or PEND
//   edge_cnt          - out_clk rising edge count, wraps
//
// state | meaning
// IDLE  | out_clk low, acc held at 0; waits for en with a nonzero increment
// RUN   | accumulating; new frequency requests accepted
// PEND  | accumulating; accepted request waits for the next out_clk fall
// STOP  | en dropped; finishes the current high phase, then IDLE
module clkgen
  import clkgen_pkg::*;
#(
  parameter int CLK_MHZ = 100,
  parameter int OUT_MHZ = 30
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             freq_valid,
  input  logic [INC_W-1:0] freq_mhz,
  output logic             freq_ready,
  output logic             freq_err,
  output logic             out_clk,
  output logic             out_stb,
  output logic             running,
  output logic [15:0]      edge_cnt
);

  localparam logic [INC_W:0] CLK_LIM = (INC_W + 1)'(CLK_MHZ);

  state_t           state;
  state_t           state_nxt;
  logic [INC_W-1:0] inc;
  logic [INC_W-1:0] pend;
  logic             pend_flag;
  logic             step;
  logic             acc_clr;
  logic             load_inc;
  logic             rise;
  logic             fall;
  logic             hs;
  logic             freq_ok;
  logic [INC_W:0]   freq_x2;

  // freq_mhz = 0 passes this test too, which is what "stop" needs.
  assign freq_x2 = {freq_mhz, 1'b0};
  assign freq_ok = (freq_x2 <= CLK_LIM);
  assign hs      = freq_valid && freq_ready;
  assign running = (state == ST_RUN) || (state == ST_PEND);

  clkgen_acc #(
    .CLK_MHZ(CLK_MHZ)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .step   (step),
    .clr    (acc_clr),
    .inc    (inc),
    .out_clk(out_clk),
    .rise   (rise),
    .fall   (fall)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    step       = 1'b0;
    acc_clr    = 1'b0;
    freq_ready = 1'b0;
    load_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        freq_ready = 1'b1;
        acc_clr    = 1'b1;
        if (en && (inc != '0)) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        freq_ready = 1'b1;
        step       = 1'b1;
        if (!en)                  state_nxt = ST_STOP;
        else if (hs && freq_ok)   state_nxt = ST_PEND;
      end
      ST_PEND: begin
        step = 1'b1;
        if (!en) begin
          state_nxt = ST_STOP;
        end else if (fall) begin
          // Switch on the low transition so no phase is shortened.
          acc_clr   = 1'b1;
          load_inc  = 1'b1;
          state_nxt = (pend == '0) ? ST_IDLE : ST_RUN;
        end
      end
      ST_STOP: begin
        if (!out_clk) begin
          acc_clr   = 1'b1;
          load_inc  = pend_flag;
          state_nxt = ST_IDLE;
        end else begin
          step = 1'b1;
          if (fall) begin
            acc_clr   = 1'b1;
            load_inc  = pend_flag;
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Handshakes only happen in IDLE/RUN and loads only in PEND/STOP,
  // so the two updates of inc never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc       <= INC_W'(OUT_MHZ);
      pend      <= '0;
      pend_flag <= 1'b0;
      freq_err  <= 1'b0;
    end else begin
      if (hs) begin
        if (freq_ok) begin
          pend <= freq_mhz;
          if (state == ST_IDLE) inc       <= freq_mhz;
          else                  pend_flag <= 1'b1;
        end else begin
          freq_err <= 1'b1;
        end
      end
      if (load_inc) begin
        inc       <= pend;
        pend_flag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_stb  <= 1'b0;
      edge_cnt <= '0;
    end else begin
      out_stb <= rise;
      if (rise) edge_cnt <= edge_cnt + 16'd1;
    end
  end

endmodule
